// File: rtl/interval_timer.sv
// Programmable interval timer: divides the system clock by a loadable divisor
// and emits one-cycle tick pulses, in one-shot or periodic mode.
module interval_timer #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         load,
    input  logic [W-1:0] divisor,
    input  logic         mode,
    input  logic         start,
    input  logic         stop,
    output logic         tick,
    output logic         running,
    output logic         done,
    output logic [W-1:0] count
);

    typedef enum logic {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } mode_e;

    logic [W-1:0] div_q, div_d;
    logic [W-1:0] cnt_q, cnt_d;
    mode_e        mode_q, mode_d;
    logic         run_q, run_d;
    logic         tick_q, tick_d;
    logic         done_q, done_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        div_d  = div_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = done_q;
        tick_d = 1'b0;

        if (load) begin
            div_d  = divisor;
            mode_d = mode_e'(mode);
            cnt_d  = divisor;
            run_d  = 1'b0;
            done_d = 1'b0;
        end else if (stop) begin
            run_d = 1'b0;
        end else if (start && !run_q) begin
            // A zero divisor can never reach terminal count, so it never starts.
            if (div_q != '0) begin
                run_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d  = div_q;
                    done_d = 1'b0;
                end
            end
        end else if (run_q) begin
            if (cnt_q > W'(1)) begin
                cnt_d = cnt_q - W'(1);
            end else if (cnt_q == W'(1)) begin
                tick_d = 1'b1;
                if (mode_q == PERIODIC) begin
                    cnt_d = div_q;
                end else begin
                    cnt_d  = '0;
                    run_d  = 1'b0;
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            div_q  <= '0;
            mode_q <= ONE_SHOT;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so all state updates see pre-edge values.
            div_q  <= div_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            tick_q <= tick_d;
            done_q <= done_d;
        end
    end

    assign tick    = tick_q;
    assign running = run_q;
    assign done    = done_q;
    assign count   = cnt_q;

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer: directed scenarios plus random commands,
// compared against a behavioural model of the timer's rules.
module tb_interval_timer;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset_ = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] divisor = '0;
    logic         mode = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         tick;
    logic         running;
    logic         done;
    logic [W-1:0] count;

    interval_timer #(.W(W)) dut (
        .clock   (clock),
        .reset_  (reset_),
        .load    (load),
        .divisor (divisor),
        .mode    (mode),
        .start   (start),
        .stop    (stop),
        .tick    (tick),
        .running (running),
        .done    (done),
        .count   (count)
    );

    always #4 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef logic [W+2:0] obs_t;  // {tick, running, done, count}
    obs_t exp_q[$];

    // Reference model: timer described as "edges left until the next tick".
    logic [W-1:0] m_div = '0;
    bit           m_periodic = 0;
    logic [W-1:0] m_left = '0;
    bit           m_run = 0;
    bit           m_done = 0;
    bit           m_tick = 0;

    task automatic check(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got tick/run/done/count=%0b/%0b/%0b/%0d want %0b/%0b/%0b/%0d",
                     name, $time, act[W+2], act[W+1], act[W], act[W-1:0],
                     exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
        end
    endtask

    task automatic model_reset();
        m_div = '0; m_periodic = 0; m_left = '0;
        m_run = 0;  m_done = 0;     m_tick = 0;
    endtask

    task automatic model_edge(input bit l, input logic [W-1:0] d, input bit m,
                              input bit s, input bit p);
        bool_tick: begin
            bit fire;
            fire = 0;
            if (l) begin
                m_div = d; m_periodic = m; m_left = d; m_run = 0; m_done = 0;
            end else if (p) begin
                m_run = 0;
            end else if (s && !m_run) begin
                if (m_div != 0) begin
                    if (m_left == 0) begin
                        m_left = m_div;
                        m_done = 0;
                    end
                    m_run = 1;
                end
            end else if (m_run) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    fire = 1;
                    if (m_periodic) m_left = m_div;
                    else begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
            end
            m_tick = fire;
        end
    endtask

    // Apply inputs, let one rising edge sample them, and queue the expected outputs.
    task automatic cyc(input bit l, input logic [W-1:0] d, input bit m,
                       input bit s, input bit p);
        load = l; divisor = d; mode = m; start = s; stop = p;
        @(posedge clock);
        if (!reset_) model_reset();
        else model_edge(l, d, m, s, p);
        exp_q.push_back({m_tick, m_run, m_done, m_left});
        #1;
        load = 0; start = 0; stop = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0);
    endtask

    task automatic async_reset_check();
        @(negedge clock);
        #1;
        reset_ = 0;
        #1;
        check("async_reset", {tick, running, done, count}, '0);
        model_reset();
    endtask

    // Monitor: outputs are stable at the falling edge; compare against the oldest expectation.
    initial begin
        obs_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", {tick, running, done, count}, e);
            end
        end
    end

    initial begin
        #10;
        check("reset_state", {tick, running, done, count}, '0);
        @(posedge clock);
        #1;
        reset_ = 1;

        // Reset mid-run, then start is ignored because DIV returns to 0.
        cyc(1, 5, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(2);
        async_reset_check();
        idle(2);
        reset_ = 1;
        cyc(0, 0, 0, 1, 0);
        idle(3);

        // One-shot N=4.
        cyc(1, 4, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(6);

        // Periodic N=3 for 10 cycles.
        cyc(1, 3, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(10);

        // Pause at count 4 and resume, N=6.
        cyc(1, 6, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(2);
        cyc(0, 0, 0, 0, 1);
        idle(4);
        cyc(0, 0, 0, 1, 0);
        idle(6);

        // Simultaneous commands.
        cyc(1, 3, 1, 1, 0);
        idle(1);
        cyc(0, 0, 0, 1, 0);
        idle(1);
        cyc(0, 0, 0, 1, 1);
        idle(1);

        // Stop on the terminal-count edge, then resume to the tick.
        cyc(1, 3, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(2);
        cyc(0, 0, 0, 0, 1);
        idle(2);
        cyc(0, 0, 0, 1, 0);
        idle(3);

        // DIV=0 cannot start; DIV=1 periodic holds tick until stop.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(2);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(4);
        cyc(0, 0, 0, 0, 1);
        idle(2);

        // Randomized command mix.
        for (int i = 0; i < 800; i++) begin
            bit l, s, p, m;
            logic [W-1:0] d;
            l = ($urandom_range(0, 99) < 6);
            p = ($urandom_range(0, 99) < 8);
            s = ($urandom_range(0, 99) < 20);
            m = 1'($urandom_range(0, 1));
            d = W'($urandom_range(0, 6));
            cyc(l, d, m, s, p);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
